// File: rtl/bypass_pkg.sv
// ---------------------------------------------------------------------------
// bypass_pkg
// Shared definitions for the bypass counter checker:
//   bp_state_t  - checker FSM state (IDLE, RUN, DONE)
//   ERR_*       - bit positions inside the sticky err vector
//   lowbit()    - isolates the lowest set bit of a word (x & -x)
// ---------------------------------------------------------------------------
package bypass_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bp_state_t;

    localparam int ERR_MASK = 0;
    localparam int ERR_SEQ  = 1;
    localparam int ERR_OVF  = 2;

    // lowbit() works on a fixed 32-bit container; callers zero-extend their
    // word and take back the bits they need. Masks wider than 32 bits are
    // not supported.
    localparam int LOWBIT_W = 32;

    function automatic logic [LOWBIT_W-1:0] lowbit(input logic [LOWBIT_W-1:0] x);
        return x & (~x + LOWBIT_W'(1));
    endfunction

endpackage

// File: rtl/bypass_popcnt.sv
// ---------------------------------------------------------------------------
// bypass_popcnt
// Combinational dense precision index: number of bits set in i_word that are
// not bypassed by i_mask.
//   i_word  [WIDTH] : received mask word
//   i_mask  [WIDTH] : latched bypass mask (1 = bit bypassed)
//   o_count [IDXW]  : popcount(i_word & ~i_mask)
// ---------------------------------------------------------------------------
module bypass_popcnt #(
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_word,
    input  logic [WIDTH-1:0] i_mask,
    output logic [IDXW-1:0]  o_count
);

    logic [WIDTH-1:0] w_live;

    assign w_live = i_word & ~i_mask;

    always_comb begin
        o_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_count = o_count + IDXW'(w_live[i]);
        end
    end

endmodule

// File: rtl/bypass_ctr_checker.sv
// ---------------------------------------------------------------------------
// bypass_ctr_checker
// Receive-side decoder/checker for the bypass counter's precision-mask
// sequence. A run starts with `start`, which latches the bypass mask. Each
// accepted word is turned into a dense precision index and checked against
// the expected sequence; errors are sticky until the next start or reset.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, bp[WIDTH]    : run start pulse and bypass mask sampled with it
//   in_valid/in_ready   : input handshake for in_cnt[WIDTH] / in_ovf
//   out_valid/out_ready : output handshake for out_idx[IDXW] / out_last
//   err[3]              : sticky {ovf mismatch, sequence, mask} flags
//   busy, done          : state is RUN / state is DONE
//   dbg_state           : raw FSM state for debug and checkers
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. in_ready depends combinationally on start and out_ready;
// out_valid holds, with out_idx/out_last stable, until out_ready is seen.
// ---------------------------------------------------------------------------
module bypass_ctr_checker
    import bypass_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] bp,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_cnt,
    input  logic             in_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last,
    output logic [2:0]       err,
    output logic             busy,
    output logic             done,
    output bp_state_t        dbg_state
);

    bp_state_t               r_state;
    bp_state_t               w_state_nxt;
    logic [WIDTH-1:0]        r_bp;
    logic [WIDTH-1:0]        r_exp;
    logic                    r_out_valid;
    logic [IDXW-1:0]         r_out_idx;
    logic                    r_out_last;
    logic [2:0]              r_err;

    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_exp_full;
    logic [WIDTH-1:0]        w_rem;
    logic [LOWBIT_W-1:0]     w_low_full;
    logic [WIDTH-1:0]        w_low;
    logic                    w_unused_low;
    logic [IDXW-1:0]         w_idx;
    logic [2:0]              w_err_set;

    // Termination is judged on the expected word, so a run always takes
    // exactly popcount(~bp)+1 accepts regardless of what arrives.
    assign w_exp_full   = (r_exp == ~r_bp);
    assign w_rem        = ~r_bp & ~r_exp;
    assign w_low_full   = lowbit(LOWBIT_W'(w_rem));
    assign w_low        = w_low_full[WIDTH-1:0];
    assign w_unused_low = ^w_low_full;

    bypass_popcnt #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_popcnt (
        .i_word  (in_cnt),
        .i_mask  (r_bp),
        .o_count (w_idx)
    );

    always_comb begin
        w_err_set           = '0;
        w_err_set[ERR_MASK] = |(in_cnt & r_bp);
        w_err_set[ERR_SEQ]  = (in_cnt != r_exp);
        w_err_set[ERR_OVF]  = (in_ovf != w_exp_full);
    end

    // Next state and input ready. start overrides everything and blocks
    // acceptance in its own cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            IDLE: ;
            RUN: begin
                w_in_ready = !r_out_valid || out_ready;
                if (in_valid && w_in_ready && w_exp_full) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: ;
            default: w_state_nxt = IDLE;
        endcase
        if (start) begin
            w_state_nxt = RUN;
            w_in_ready  = 1'b0;
        end
    end

    assign w_accept = in_valid && w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bp        <= '0;
            r_exp       <= '0;
            r_err       <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
        end else if (start) begin
            // A pending result from the previous run is discarded.
            r_bp        <= bp;
            r_exp       <= '0;
            r_err       <= '0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_idx   <= w_idx;
            r_out_last  <= (in_cnt == ~r_bp);
            r_err       <= r_err | w_err_set;
            // w_low is zero once every live bit is set, so exp_q saturates.
            r_exp       <= r_exp | w_low;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;
    assign err       = r_err;
    assign busy      = (r_state == RUN);
    assign done      = (r_state == DONE);
    assign dbg_state = r_state;

endmodule
